// File: rtl/dmem_mmio_pkg.sv
// dmem_mmio_pkg: address-map constants and shared enums for the MIPS data memory / MMIO block.
package dmem_mmio_pkg;
   localparam logic [15:0] IO_HI        = 16'hFFFF;
   localparam logic [15:0] GPIO_OUT_OFS = 16'h0000;
   localparam logic [15:0] GPIO_IN_OFS  = 16'h0080;
   typedef enum logic {IDLE, WAIT} rd_state_t;
   typedef enum logic [1:0] {REG_RAM, REG_GPIO_OUT, REG_GPIO_IN, REG_UNMAPPED} region_t;
endpackage

// File: rtl/dmem_mmio_sync2.sv
// mmio_sync2: parametrised-width two-flop synchroniser, asynchronously reset to zero.
module mmio_sync2 #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);
   logic [W-1:0] r_meta, r_q;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         r_meta <= '0;
         r_q    <= '0;
      end else begin
         r_meta <= i_d;
         r_q    <= r_meta;
      end
   assign o_q = r_q;
endmodule

// File: rtl/dmem_mmio.sv
// dmem_mmio: byte-enabled data RAM with memory-mapped GPIO and a req/ready/rvalid handshake.
// Define GPIO_ACTIVE_LOW_EN to drive gpio_out inverted for active-low board LEDs.
module dmem_mmio
   import dmem_mmio_pkg::*;
#(
   parameter int DEPTH_WORDS = 64,
   parameter int N_GPIO      = 2,
   parameter int GPIO_W      = 8,
   parameter int RD_LAT      = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     req,
   input  logic                     we,
   input  logic [3:0]               be,
   input  logic [31:0]              addr,
   input  logic [31:0]              wdata,
   output logic                     ready,
   output logic                     rvalid,
   output logic [31:0]              rdata,
   output logic                     err,
   output logic [N_GPIO*GPIO_W-1:0] gpio_out,
   input  logic [GPIO_W-1:0]        gpio_in
);
   localparam int AW = $clog2(DEPTH_WORDS);

   rd_state_t                r_state;
   logic [2:0]               r_cnt;
   logic [31:0]              r_hold, r_rdata;
   logic                     r_rvalid, r_err;
   logic [N_GPIO*GPIO_W-1:0] r_gpio;
   logic [31:0]              r_mem [DEPTH_WORDS];
   logic [GPIO_W-1:0]        w_gin, w_gmask, w_gsel;
   logic [13:0]              w_gofs;
   logic [AW-1:0]            w_idx;
   region_t                  w_region;
   logic [31:0]              w_rd_data;
   logic                     w_acc, w_wr, w_unused;

   mmio_sync2 #(.W(GPIO_W)) u_sync (.clk(clk), .reset(reset), .i_d(gpio_in), .o_q(w_gin));

   assign w_unused = ^addr[1:0];
   assign w_idx    = addr[AW+1:2];
   assign w_gofs   = addr[15:2] - GPIO_OUT_OFS[15:2];
   assign ready    = (r_state == IDLE);
   assign w_acc    = req & ready;
   assign w_wr     = w_acc & we;
   assign rvalid   = r_rvalid;
   assign rdata    = r_rdata;
   assign err      = r_err;

   // RAM window needs the bits above the word index clear; gpio_in sits outside the GPIO out range
   always_comb
      w_region = (addr[31:16] != IO_HI) ? ((addr[15:AW+2] == '0) ? REG_RAM : REG_UNMAPPED)
               : (addr[15:2] == GPIO_IN_OFS[15:2]) ? REG_GPIO_IN
               : (w_gofs < 14'(N_GPIO)) ? REG_GPIO_OUT : REG_UNMAPPED;

   always_comb begin
      w_gsel = '0;
      for (int i = 0; i < N_GPIO; i++)
         if (w_gofs == 14'(i)) w_gsel = r_gpio[i*GPIO_W +: GPIO_W];
   end

   always_comb begin
      w_gmask = '0;
      for (int b = 0; b < GPIO_W; b++) w_gmask[b] = be[b/8];
   end

   always_comb
      w_rd_data = (w_region == REG_RAM)      ? r_mem[w_idx]
                : (w_region == REG_GPIO_OUT) ? 32'(w_gsel)
                : (w_region == REG_GPIO_IN)  ? 32'(w_gin) : '0;

   always_ff @(posedge clk)
      if (w_wr && w_region == REG_RAM)
         for (int b = 0; b < 4; b++)
            if (be[b]) r_mem[w_idx][8*b +: 8] <= wdata[8*b +: 8];

   // read data is frozen at acceptance and released after RD_LAT edges
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_hold   <= '0;
         r_rdata  <= '0;
         r_rvalid <= 1'b0;
         r_err    <= 1'b0;
         r_gpio   <= '0;
      end else begin
         r_rvalid <= 1'b0;
         r_err    <= w_acc & (w_region == REG_UNMAPPED);
         if (w_acc && !we) begin
            if (RD_LAT == 1) begin
               r_rvalid <= 1'b1;
               r_rdata  <= w_rd_data;
            end else begin
               r_state <= WAIT;
               r_cnt   <= 3'(RD_LAT - 1);
               r_hold  <= w_rd_data;
            end
         end else if (r_state == WAIT) begin
            if (r_cnt == 3'd1) begin
               r_state  <= IDLE;
               r_rvalid <= 1'b1;
               r_rdata  <= r_hold;
            end else begin
               r_cnt <= r_cnt - 3'd1;
            end
         end
         for (int i = 0; i < N_GPIO; i++)
            if (w_wr && w_region == REG_GPIO_OUT && w_gofs == 14'(i))
               r_gpio[i*GPIO_W +: GPIO_W] <= (r_gpio[i*GPIO_W +: GPIO_W] & ~w_gmask)
                                           | (wdata[GPIO_W-1:0] & w_gmask);
      end

`ifdef GPIO_ACTIVE_LOW_EN
   assign gpio_out = ~r_gpio;
`else
   assign gpio_out = r_gpio;
`endif
endmodule

// File: tb/tb_dmem_mmio.sv
// tb_dmem_mmio: directed vector table, hand-written corner sequences and randomized traffic
// checked against a word/byte-level model of the memory map.
module tb_dmem_mmio;
   localparam int DEPTH = 64, NG = 2, GW = 8, LAT = 3;

   logic              clk = 0, reset = 0, req = 0, we = 0;
   logic [3:0]        be = 0;
   logic [31:0]       addr = 0, wdata = 0;
   logic              ready, rvalid, err;
   logic [31:0]       rdata;
   logic [NG*GW-1:0]  gpio_out;
   logic [GW-1:0]     gpio_in = 0;
   int                n_chk = 0, n_err = 0;
   bit   [31:0]       m_ram [DEPTH];
   bit   [GW-1:0]     m_gpio [NG];
   bit   [GW-1:0]     m_gin;

   typedef struct {
      bit          w;
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  b;
      logic [31:0] x;
      logic        e;
   } vec_t;
   vec_t tbl [18];

   dmem_mmio #(.DEPTH_WORDS(DEPTH), .N_GPIO(NG), .GPIO_W(GW), .RD_LAT(LAT)) dut (
      .clk(clk), .reset(reset), .req(req), .we(we), .be(be), .addr(addr), .wdata(wdata),
      .ready(ready), .rvalid(rvalid), .rdata(rdata), .err(err), .gpio_out(gpio_out), .gpio_in(gpio_in)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // 0 RAM, 1 GPIO out, 2 gpio_in, 3 unmapped
   function automatic int region(input logic [31:0] a);
      int w;
      w = int'(a[15:0]) / 4;
      if (a[31:16] != 16'hFFFF) return (w < DEPTH) ? 0 : 3;
      if (w == 'h80 / 4) return 2;
      return (w < NG) ? 1 : 3;
   endfunction

   function automatic logic [31:0] m_read(input logic [31:0] a);
      int w;
      w = int'(a[15:0]) / 4;
      case (region(a))
         0: return m_ram[w];
         1: return 32'(m_gpio[w]);
         2: return 32'(m_gin);
         default: return 32'h0;
      endcase
   endfunction

   task automatic m_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
      int w;
      w = int'(a[15:0]) / 4;
      case (region(a))
         0: for (int k = 0; k < 32; k++) if (b[k/8]) m_ram[w][k] = d[k];
         1: for (int k = 0; k < GW; k++) if (b[k/8]) m_gpio[w][k] = d[k];
         default: ;
      endcase
   endtask

   function automatic logic [NG*GW-1:0] m_gpio_out();
      logic [NG*GW-1:0] v;
      for (int i = 0; i < NG; i++) v[i*GW +: GW] = m_gpio[i];
`ifdef GPIO_ACTIVE_LOW_EN
      return ~v;
`else
      return v;
`endif
   endfunction

   task automatic wait_ready();
      for (int n = 0; !ready; n++) begin
         if (n == 20) begin
            n_chk++;
            n_err++;
            $display("FAIL ready_timeout: ready %b expected 1", ready);
            return;
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b, output logic e);
      addr = a; wdata = d; be = b; we = 1; req = 1;
      wait_ready();
      @(posedge clk);
      #1;
      req = 0; we = 0;
      m_write(a, d, b);
      e = err;
      chk("wr_err", 32'(err), 32'(region(a) == 3));
      chk("wr_rvalid", 32'(rvalid), 32'h0);
      chk("wr_ready", 32'(ready), 32'h1);
      chk("wr_gpio_out", 32'(gpio_out), 32'(m_gpio_out()));
   endtask

   // junk=1 keeps a write request asserted while ready is low; it must be ignored
   task automatic rd(input logic [31:0] a, input bit junk, output logic [31:0] d, output logic e);
      logic [31:0] x;
      x = m_read(a);
      addr = a; we = 0; be = 4'($urandom); req = 1;
      wait_ready();
      @(posedge clk);
      #1;
      req = 0;
      if (junk) begin
         req = 1; we = 1; addr = 32'h20; wdata = 32'hFFFF_FFFF; be = 4'hF;
      end
      e = err;
      chk("rd_err", 32'(err), 32'(region(a) == 3));
      for (int k = 1; k < LAT; k++) begin
         chk("rd_ready_low", 32'(ready), 32'h0);
         chk("rd_rvalid_early", 32'(rvalid), 32'h0);
         @(posedge clk);
         #1;
         if (k == 1) chk("rd_err_pulse", 32'(err), 32'h0);
      end
      req = 0; we = 0;
      chk("rd_rvalid", 32'(rvalid), 32'h1);
      chk("rd_ready", 32'(ready), 32'h1);
      chk("rd_data", rdata, x);
      d = rdata;
   endtask

   initial begin
      logic [31:0] d, a;
      logic        e;
      int          kind, sel;

      tbl[0]  = '{1'b1, 32'h0000_0000, 32'h0BAD_F00D, 4'hF, 32'h0,          1'b0};
      tbl[1]  = '{1'b1, 32'h0000_0010, 32'h1234_5678, 4'hF, 32'h0,          1'b0};
      tbl[2]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'h1234_5678,  1'b0};
      tbl[3]  = '{1'b1, 32'h0000_0014, 32'h0,         4'hF, 32'h0,          1'b0};
      tbl[4]  = '{1'b1, 32'h0000_0014, 32'hAABB_CCDD, 4'h5, 32'h0,          1'b0};
      tbl[5]  = '{1'b0, 32'h0000_0014, 32'h0,         4'h0, 32'h00BB_00DD,  1'b0};
      tbl[6]  = '{1'b1, 32'hFFFF_0004, 32'h0000_00A5, 4'hF, 32'h0,          1'b0};
      tbl[7]  = '{1'b0, 32'hFFFF_0004, 32'h0,         4'h0, 32'h0000_00A5,  1'b0};
      tbl[8]  = '{1'b0, 32'hFFFF_0100, 32'h0,         4'h0, 32'h0,          1'b1};
      tbl[9]  = '{1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 32'h0,          1'b1};
      tbl[10] = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'h0BAD_F00D,  1'b0};
      tbl[11] = '{1'b1, 32'hFFFF_0080, 32'hFFFF_FFFF, 4'hF, 32'h0,          1'b0};
      tbl[12] = '{1'b1, 32'hFFFF_0000, 32'h0000_1234, 4'h2, 32'h0,          1'b0};
      tbl[13] = '{1'b0, 32'hFFFF_0000, 32'h0,         4'h0, 32'h0,          1'b0};
      tbl[14] = '{1'b1, 32'hFFFF_0000, 32'h0000_0077, 4'h1, 32'h0,          1'b0};
      tbl[15] = '{1'b0, 32'hFFFF_0002, 32'h0,         4'h0, 32'h0000_0077,  1'b0};
      tbl[16] = '{1'b1, 32'hFFFF_0008, 32'h0000_0011, 4'hF, 32'h0,          1'b1};
      tbl[17] = '{1'b0, 32'h0000_FFFC, 32'h0,         4'h0, 32'h0,          1'b1};

      #1 reset = 1;
      #2;
      chk("rst_ready", 32'(ready), 32'h1);
      chk("rst_rvalid", 32'(rvalid), 32'h0);
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_err", 32'(err), 32'h0);
      chk("rst_gpio_out", 32'(gpio_out), 32'(m_gpio_out()));
      @(negedge clk) reset = 0;
      @(posedge clk);
      #1;

      for (int i = 0; i < 18; i++) begin
         if (tbl[i].w) wr(tbl[i].a, tbl[i].d, tbl[i].b, e);
         else begin
            rd(tbl[i].a, 0, d, e);
            chk($sformatf("tbl%0d_rdata", i), d, tbl[i].x);
         end
         chk($sformatf("tbl%0d_err", i), 32'(e), 32'(tbl[i].e));
      end
`ifdef GPIO_ACTIVE_LOW_EN
      chk("tbl_gpio_out", 32'(gpio_out), 32'h0000_5A88);
`else
      chk("tbl_gpio_out", 32'(gpio_out), 32'h0000_A577);
`endif

      wr(32'h20, 32'hCAFE_BABE, 4'hF, e);
      rd(32'h10, 1, d, e);
      rd(32'h20, 0, d, e);
      chk("ignored_req", d, 32'hCAFE_BABE);

      gpio_in = 8'h3C;
      m_gin = 8'h3C;
      @(posedge clk);
      @(posedge clk);
      #1;
      rd(32'hFFFF_0080, 0, d, e);
      chk("gpio_in_read", d, 32'h0000_003C);

      addr = 32'h10; we = 0; req = 1;
      wait_ready();
      @(posedge clk);
      #1 req = 0;
      @(posedge clk);
      #1 reset = 1;
      #2;
      for (int i = 0; i < NG; i++) m_gpio[i] = '0;
      chk("rstmid_rvalid", 32'(rvalid), 32'h0);
      chk("rstmid_ready", 32'(ready), 32'h1);
      chk("rstmid_rdata", rdata, 32'h0);
      chk("rstmid_gpio_out", 32'(gpio_out), 32'(m_gpio_out()));
      @(negedge clk) reset = 0;
      for (int k = 0; k < LAT + 2; k++) begin
         @(posedge clk);
         #1 chk("rstmid_no_rvalid", 32'(rvalid), 32'h0);
      end
      m_gin = gpio_in;

      for (int i = 0; i < DEPTH; i++) wr(32'(i) * 4, $urandom, 4'hF, e);
      for (int n = 0; n < 300; n++) begin
         kind = $urandom_range(0, 9);
         sel  = $urandom_range(0, 5);
         case (sel)
            0, 1, 2: a = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(0, 3));
            3:       a = 32'hFFFF_0000 | (32'($urandom_range(0, NG)) << 2) | 32'($urandom_range(0, 3));
            4:       a = 32'hFFFF_0080 | 32'($urandom_range(0, 3));
            default: a = $urandom_range(0, 1) ? {16'hFFFF, 16'($urandom)}
                                              : {16'($urandom_range(0, 16'hFFFE)),
                                                 16'($urandom_range(DEPTH * 4, 16'hFFFF))};
         endcase
         if (kind == 0) begin
            gpio_in = GW'($urandom);
            m_gin = gpio_in;
            @(posedge clk);
            @(posedge clk);
            #1;
         end else if (kind < 5) wr(a, $urandom, 4'($urandom), e);
         else rd(a, 0, d, e);
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/dmem_mmio.md
Name: dmem_mmio

Overview:
Parametrised data memory for the MIPS cores, with memory-mapped GPIO and a req/ready/rvalid handshake. It replaces the single-cycle word-only dmem and its hard-wired LED tap. It adds byte-enable writes, configurable depth, multiple GPIO output channels, one synchronised input channel and configurable read latency. It sits between the core's load/store port and board I/O, and serves both single-cycle (RD_LAT=1 is the nearest equivalent) and the planned multicycle core.

Parameters:
DEPTH_WORDS, 64, RAM words; power of 2, 16..4096
N_GPIO, 2, number of output channels, 1..8
GPIO_W, 8, bits per output/input channel, 1..32
RD_LAT, 1, cycles from read acceptance to rvalid, 1..4

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
req  in  1  access request
we  in  1  1=write, 0=read; sampled with req
be  in  4  byte enables for writes, bit i -> wdata[8i+7:8i]
addr  in  32  byte address; [1:0] ignored
wdata  in  32  write data
ready  out  1  request accepted this cycle when req&ready
rvalid  out  1  one-cycle pulse, rdata valid
rdata  out  32  read data
err  out  1  one-cycle pulse: access to unmapped address
gpio_out  out  N_GPIO*GPIO_W  output channels, channel i at [i*GPIO_W +: GPIO_W]
gpio_in  in  GPIO_W  asynchronous input channel

Behaviour:
- Reset: clk is the clock; reset is asynchronous, active-high. ready=1, rvalid=0, rdata=0, err=0, GPIO regs=0, latency counter cleared. RAM is not reset.
- Address map:
  - addr[31:16]!=16'hFFFF: RAM word addr[log2(DEPTH_WORDS)+1:2]; addr[15:log2(DEPTH_WORDS)+2] must be 0, else unmapped.
  - 0xFFFF_0000+4*i, i<N_GPIO: GPIO out reg i.
  - 0xFFFF_0080: gpio_in (read-only; writes ignored, no err).
  - Anything else in 0xFFFF_xxxx: unmapped.
- Write (req&we&ready):
  - Completes at that clock edge; ready stays 1.
  - RAM byte lanes with be=1 updated.
  - GPIO reg gets wdata[GPIO_W-1:0] masked per byte lane by be.
  - be=0: accepted no-op.
  - No rvalid.
- Read (req&!we&ready):
  - States IDLE -> WAIT. ready=0 in the next RD_LAT-1 cycles after acceptance (RD_LAT=1: ready never drops).
  - Data captured at the acceptance edge.
  - rvalid=1 and rdata presented exactly RD_LAT cycles after the acceptance edge. Return to IDLE that cycle, so ready=1 in the same cycle as rvalid.
  - GPIO reads return the register zero-extended. gpio_in reads return the synchronised value zero-extended.
  - be ignored.
- rdata holds its last value until the next rvalid.
- Unmapped access: write dropped; read returns 0 with a normal rvalid. err pulses in the cycle after acceptance.
- Read-after-write to the same word in back-to-back cycles returns the new data.
- req while ready=0: ignored. The requester must hold req until accepted.
- gpio_in passes through a 2-flop synchroniser; 2-cycle latency to readability.
- Reset mid-read: the pending read is dropped; no rvalid after reset deasserts.

Optional Feature:
GPIO_ACTIVE_LOW_EN.
- Defined: gpio_out is the bitwise inverse of the GPIO regs (active-low board LEDs); after reset gpio_out is all ones. Register readback is uninverted.
- Undefined: gpio_out equals the regs; after reset gpio_out=0.

Decomposition:
- Package dmem_mmio_pkg:
  - IO_HI=16'hFFFF, GPIO_OUT_OFS=16'h0000, GPIO_IN_OFS=16'h0080.
  - typedef enum {IDLE, WAIT} rd_state_t.
  - typedef enum {REG_RAM, REG_GPIO_OUT, REG_GPIO_IN, REG_UNMAPPED} region_t.
- One sub-module, mmio_sync2: parametrised-width 2-flop synchroniser with async reset to 0.

Test Plan:
- Write 0x12345678 to 0x0000_0010 with be=4'b1111, then read with RD_LAT=3 -> ready low 2 cycles, rvalid 3 cycles after acceptance, rdata=0x12345678.
- Write 0xAABBCCDD with be=4'b0101 over a word holding 0 -> read returns 0x00BB00DD.
- Write 0x0000_00A5 to 0xFFFF_0004 (N_GPIO=2, GPIO_W=8) -> gpio_out[15:8]=0xA5 the next cycle (0x5A with GPIO_ACTIVE_LOW_EN); readback 0x0000_00A5.
- Drive gpio_in=0x3C -> read of 0xFFFF_0080 issued ≥3 cycles later returns 0x0000_003C.
- Read 0xFFFF_0100 -> rdata=0, rvalid normal, err pulses one cycle after acceptance. Write to RAM index DEPTH_WORDS -> err, no RAM change.
- Assert reset during WAIT with RD_LAT=4 -> no rvalid, ready=1, gpio_out=0 (all ones with the feature), rdata=0.
